// File: rtl/jericalla_pkg.sv
// Shared enums for the multi-cycle Jericalla datapath: command kinds, ALU ops, FSM states.
package jericalla_pkg;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_NOP   = 2'd3
    } cmd_kind_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/jericalla_alu_p.sv
// Combinational W-bit ALU with signed-overflow indication for ADD/SUB.
module jericalla_alu_p
    import jericalla_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y,
    output logic           ovf
);

    localparam int unsigned SHW = $clog2(W);

    // Operation select; overflow only meaningful for ADD/SUB
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        unique case (op)
            ALU_ADD: begin
                y   = a + b;
                ovf = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                y   = a - b;
                ovf = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = W'($signed(a) < $signed(b));
            ALU_SLL: y = a << b[SHW-1:0];
            ALU_SRL: y = a >> b[SHW-1:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/jericalla_multiciclo.sv
// Multi-cycle Jericalla: IDLE->READ->EXEC->MEM->WB sequencer around regfile, ALU,
// data memory and per-channel result demux. Optional flags: define JERICALLA_FLAGS_EN.
module jericalla_multiciclo
    import jericalla_pkg::*;
#(
    parameter  int unsigned W      = 32,
    parameter  int unsigned NREG   = 32,
    parameter  int unsigned MDEPTH = 32,
    parameter  int unsigned NCH    = 4,
    localparam int unsigned RAW    = $clog2(NREG),
    localparam int unsigned MAW    = $clog2(MDEPTH),
    localparam int unsigned CW     = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [2:0]        cmd_alu,
    input  logic [RAW-1:0]    cmd_rs1,
    input  logic [RAW-1:0]    cmd_rs2,
    input  logic [RAW-1:0]    cmd_rd,
    input  logic              cmd_imm_en,
    input  logic [W-1:0]      cmd_imm,
    input  logic [CW-1:0]     cmd_ch,
    output logic              busy,
    output logic [NCH*W-1:0]  ch_data,
    output logic [NCH-1:0]    ch_valid,
    output logic              flag_z,
    output logic              flag_v
);

    state_e          state_q, state_d;
    cmd_kind_e       kind_q;
    alu_op_e         op_q;
    logic [RAW-1:0]  rs1_q, rs2_q, rd_q;
    logic            imm_en_q;
    logic [W-1:0]    imm_q;
    logic [CW-1:0]   ch_q;
    logic [W-1:0]    a_q, b_q, s_q, alu_res_q, result_q;
    logic [W-1:0]    rf  [NREG];
    logic [W-1:0]    mem [MDEPTH];
    logic [W-1:0]    rd_a, rd_b, alu_y, result_c;
    logic [MAW-1:0]  addr;
    logic            alu_ovf;
    alu_op_e         alu_op;

    // State register plus registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Next-state: fixed five-step sequence
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_MEM;
            ST_MEM:  state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= KIND_ALU;
            op_q     <= ALU_ADD;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            ch_q     <= '0;
        end else if (state_q == ST_IDLE && cmd_valid) begin
            kind_q   <= cmd_kind_e'(cmd_kind);
            op_q     <= alu_op_e'(cmd_alu);
            rs1_q    <= cmd_rs1;
            rs2_q    <= cmd_rs2;
            rd_q     <= cmd_rd;
            imm_en_q <= cmd_imm_en;
            imm_q    <= cmd_imm;
            ch_q     <= cmd_ch;
        end
    end

    assign rd_a   = (rs1_q == '0) ? '0 : rf[rs1_q];
    assign rd_b   = (rs2_q == '0) ? '0 : rf[rs2_q];
    assign alu_op = (kind_q == KIND_ALU) ? op_q : ALU_ADD;
    assign addr   = alu_res_q[MAW-1:0];

    jericalla_alu_p #(.W(W)) u_alu (
        .op  (alu_op),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    // Result selection during MEM (load data read straight from memory)
    always_comb begin
        result_c = '0;
        unique case (kind_q)
            KIND_ALU:   result_c = alu_res_q;
            KIND_LOAD:  result_c = mem[addr];
            KIND_STORE: result_c = s_q;
            default:    result_c = '0;
        endcase
    end

    // Datapath registers, regfile write-back and channel demux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            alu_res_q <= '0;
            result_q  <= '0;
            ch_data   <= '0;
            ch_valid  <= '0;
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else begin
            ch_valid <= '0;
            unique case (state_q)
                ST_READ: begin
                    a_q <= rd_a;
                    b_q <= imm_en_q ? imm_q : rd_b;
                    s_q <= rd_b;
                end
                ST_EXEC: alu_res_q <= alu_y;
                ST_MEM: begin
                    result_q <= result_c;
                    ch_valid <= NCH'(1) << ch_q;
                    for (int i = 0; i < int'(NCH); i++) begin
                        if (ch_q == CW'(i)) ch_data[i*W +: W] <= result_c;
                    end
                end
                ST_WB: begin
                    if ((kind_q == KIND_ALU || kind_q == KIND_LOAD) && rd_q != '0)
                        rf[rd_q] <= result_q;
                end
                default: ;
            endcase
        end
    end

    // Data memory: unreset storage, written at the MEM-exit edge of a STORE
    always_ff @(posedge clk) begin
        if (state_q == ST_MEM && kind_q == KIND_STORE) mem[addr] <= s_q;
    end

`ifdef JERICALLA_FLAGS_EN
    // Status flags captured from the ALU result of ALU commands only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else if (state_q == ST_EXEC && kind_q == KIND_ALU) begin
            flag_z <= (alu_y == '0);
            flag_v <= alu_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
    assign flag_z     = 1'b0;
    assign flag_v     = 1'b0;
`endif

endmodule

// File: tb/tb_jericalla_multiciclo.sv
// Self-checking bench for jericalla_multiciclo against a behavioural command-level model.
module tb_jericalla_multiciclo;
    import jericalla_pkg::*;

    localparam int W = 32, NREG = 32, MDEPTH = 32, NCH = 4;
    localparam int RAW = $clog2(NREG), CW = $clog2(NCH);
`ifdef JERICALLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_imm_en = 1'b0, busy, flag_z, flag_v;
    logic [1:0]        cmd_kind = '0;
    logic [2:0]        cmd_alu = '0;
    logic [RAW-1:0]    cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
    logic [W-1:0]      cmd_imm = '0;
    logic [CW-1:0]     cmd_ch = '0;
    logic [NCH*W-1:0]  ch_data;
    logic [NCH-1:0]    ch_valid;

    jericalla_multiciclo #(.W(W), .NREG(NREG), .MDEPTH(MDEPTH), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_alu(cmd_alu), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_rd(cmd_rd), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_ch(cmd_ch),
        .busy(busy), .ch_data(ch_data), .ch_valid(ch_valid), .flag_z(flag_z), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_reg [NREG];
    logic [W-1:0] m_mem [MDEPTH];
    logic [W-1:0] m_ch  [NCH];
    logic         m_fz, m_fv;
    int passed = 0, total = 0;

    // Observations of the last command
    logic [W-1:0]     o_data;
    int               o_lat, o_rlow;
    logic [NCH-1:0]   o_vld;
    logic             o_fz, o_fv;
    logic [NCH*W-1:0] o_all;
    logic [W-1:0]     e_data;

    function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                             output logic ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint maxv = (longint'(1) <<< (W-1)) - 1;
        longint minv = -(longint'(1) <<< (W-1));
        longint full;
        ov = 1'b0;
        case (op)
            0: begin full = sa + sb; ov = (full > maxv) || (full < minv); return a + b; end
            1: begin full = sa - sb; ov = (full > maxv) || (full < minv); return a - b; end
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sa < sb) ? 1 : 0;
            6: return a << (b % W);
            default: return a >> (b % W);
        endcase
    endfunction

    function automatic logic [NCH*W-1:0] model_chv();
        logic [NCH*W-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*W +: W] = m_ch[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        for (int i = 0; i < NCH; i++) m_ch[i] = '0;
        m_fz = 1'b0;
        m_fv = 1'b0;
    endtask

    // Executes one command on the model and returns the channel result
    task automatic model_cmd(input int kind, input int op, input int rs1, input int rs2, input int rd,
                             input bit imm_en, input logic [W-1:0] imm, input int ch,
                             output logic [W-1:0] exp);
        logic [W-1:0] a, b, s;
        logic ov;
        int addr;
        a = (rs1 == 0) ? '0 : m_reg[rs1];
        s = (rs2 == 0) ? '0 : m_reg[rs2];
        b = imm_en ? imm : s;
        addr = int'((a + b) % MDEPTH);
        case (kind)
            0: begin exp = ref_alu(op, a, b, ov); m_fz = (exp == 0); m_fv = ov; end
            1: exp = m_mem[addr];
            2: begin m_mem[addr] = s; exp = s; end
            default: exp = '0;
        endcase
        if ((kind == 0 || kind == 1) && rd != 0) m_reg[rd] = exp;
        m_ch[ch] = exp;
    endtask

    // Drives one command and watches the five cycles after the accept edge
    task automatic send(input int kind, input int op, input int rs1, input int rs2, input int rd,
                        input bit imm_en, input logic [W-1:0] imm, input int ch);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        cmd_kind = 2'(kind); cmd_alu = 3'(op); cmd_rs1 = RAW'(rs1); cmd_rs2 = RAW'(rs2);
        cmd_rd = RAW'(rd); cmd_imm_en = imm_en; cmd_imm = imm; cmd_ch = CW'(ch);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        o_lat = 0; o_rlow = 0; o_vld = '0; o_data = '0; o_fz = 1'b0; o_fv = 1'b0; o_all = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1) o_rlow++;
            if (ch_valid !== '0) begin
                if (o_lat == 0) begin
                    o_lat = c; o_vld = ch_valid; o_data = ch_data[ch*W +: W];
                    o_fz = flag_z; o_fv = flag_v; o_all = ch_data;
                end else o_lat = 100 + c;
            end
        end
    endtask

    task automatic do_cmd(input int kind, input int op, input int rs1, input int rs2, input int rd,
                          input bit imm_en, input logic [W-1:0] imm, input int ch);
        model_cmd(kind, op, rs1, rs2, rd, imm_en, imm, ch, e_data);
        send(kind, op, rs1, rs2, rd, imm_en, imm, ch);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (ch_valid !== '0) $display("FAIL reset_valid got=%b exp=0", ch_valid); else passed++;
        total++; if (ch_data !== '0) $display("FAIL reset_data got=%h exp=0", ch_data); else passed++;
        total++; if ({flag_z, flag_v} !== 2'b00) $display("FAIL reset_flags got=%b%b exp=00", flag_z, flag_v); else passed++;
    endtask

    task automatic test_basic();
        do_cmd(0, 0, 0, 0, 1, 1'b1, 32'd5, 2);
        total++; if (o_lat !== 4) $display("FAIL basic_latency got=%0d exp=4", o_lat); else passed++;
        total++; if (o_vld !== 4'b0100) $display("FAIL basic_onehot got=%b exp=0100", o_vld); else passed++;
        total++; if (o_data !== 32'd5) $display("FAIL basic_data got=%0d exp=5", o_data); else passed++;
        total++; if (o_rlow !== 4) $display("FAIL basic_ready_low got=%0d exp=4", o_rlow); else passed++;
        total++; if (o_all !== model_chv()) $display("FAIL basic_hold got=%h exp=%h", o_all, model_chv()); else passed++;
    endtask

    task automatic test_arith();
        do_cmd(0, 0, 0, 0, 2, 1'b1, 32'hFFFF_FFFF, 0);
        total++; if (o_data !== 32'hFFFF_FFFF) $display("FAIL r2_load got=%h exp=ffffffff", o_data); else passed++;
        do_cmd(0, 1, 1, 2, 3, 1'b0, '0, 1);
        total++; if (o_data !== 32'd6) $display("FAIL sub got=%0d exp=6", o_data); else passed++;
        do_cmd(0, 5, 2, 1, 3, 1'b0, '0, 3);
        total++; if (o_data !== 32'd1) $display("FAIL slt got=%0d exp=1", o_data); else passed++;
        do_cmd(0, 0, 2, 0, 3, 1'b1, 32'd1, 0);
        total++; if (o_data !== 32'd0) $display("FAIL add_wrap got=%h exp=0", o_data); else passed++;
        total++; if (o_fz !== FLAGS) $display("FAIL flag_z got=%b exp=%b", o_fz, FLAGS); else passed++;
    endtask

    task automatic test_mem_wrap();
        do_cmd(2, 0, 0, 1, 0, 1'b1, 32'd33, 1);
        total++; if (o_data !== 32'd5) $display("FAIL store_result got=%0d exp=5", o_data); else passed++;
        do_cmd(1, 0, 0, 0, 4, 1'b1, 32'd1, 2);
        total++; if (o_data !== 32'd5) $display("FAIL load_wrap got=%0d exp=5", o_data); else passed++;
    endtask

    task automatic test_zero_reg();
        do_cmd(0, 0, 0, 0, 0, 1'b1, 32'd7, 0);
        total++; if (o_data !== 32'd7) $display("FAIL rd0_result got=%0d exp=7", o_data); else passed++;
        do_cmd(0, 0, 0, 0, 6, 1'b0, '0, 0);
        total++; if (o_data !== 32'd0) $display("FAIL zero_reg got=%0d exp=0", o_data); else passed++;
    endtask

    task automatic test_overflow();
        do_cmd(0, 0, 0, 0, 5, 1'b1, 32'h7FFF_FFFF, 1);
        do_cmd(0, 0, 5, 0, 6, 1'b1, 32'd1, 1);
        total++; if (o_data !== 32'h8000_0000) $display("FAIL ovf_data got=%h exp=80000000", o_data); else passed++;
        total++; if (o_fv !== FLAGS) $display("FAIL flag_v got=%b exp=%b", o_fv, FLAGS); else passed++;
    endtask

    task automatic test_mem_init();
        for (int i = 0; i < MDEPTH; i++) begin
            do_cmd(2, 0, 0, 0, 0, 1'b1, W'(i), 3);
        end
        total++; if (o_data !== '0) $display("FAIL mem_init got=%h exp=0", o_data); else passed++;
    endtask

    task automatic test_random();
        int kind, op, ch;
        bit ie;
        logic [W-1:0] imm;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            op   = $urandom_range(0, 7);
            ch   = $urandom_range(0, NCH - 1);
            ie   = 1'($urandom_range(0, 1));
            imm  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 70));
            do_cmd(kind, op, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                   $urandom_range(0, NREG - 1), ie, imm, ch);
            total++; if (o_lat !== 4 || o_vld !== NCH'(1 << ch))
                $display("FAIL rnd_pulse n=%0d lat=%0d vld=%b exp_lat=4 exp_ch=%0d", n, o_lat, o_vld, ch); else passed++;
            total++; if (o_data !== e_data)
                $display("FAIL rnd_data n=%0d kind=%0d op=%0d got=%h exp=%h", n, kind, op, o_data, e_data); else passed++;
            total++; if (o_all !== model_chv())
                $display("FAIL rnd_channels n=%0d got=%h exp=%h", n, o_all, model_chv()); else passed++;
            total++; if ({o_fz, o_fv} !== ({m_fz, m_fv} & {2{FLAGS}}))
                $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, o_fz, o_fv, m_fz & FLAGS, m_fv & FLAGS); else passed++;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        do_cmd(0, 0, 0, 0, 3, 1'b1, 32'd9, 0);
        cmd_kind = 2'd2; cmd_alu = 3'd0; cmd_rs1 = '0; cmd_rs2 = RAW'(3); cmd_rd = '0;
        cmd_imm_en = 1'b1; cmd_imm = 32'd3; cmd_ch = CW'(1); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin @(negedge clk); if (ch_valid !== '0) seen++; end
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin @(negedge clk); if (ch_valid !== '0) seen++; end
        total++; if (seen !== 0) $display("FAIL abort_pulse got=%0d exp=0", seen); else passed++;
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_ready got=%b/%b exp=1/0", cmd_ready, busy); else passed++;
        total++; if (ch_data !== '0) $display("FAIL abort_data got=%h exp=0", ch_data); else passed++;
        do_cmd(1, 0, 0, 0, 7, 1'b1, 32'd3, 1);
        total++; if (o_data !== e_data) $display("FAIL abort_mem got=%h exp=%h", o_data, e_data); else passed++;
        do_cmd(0, 0, 3, 0, 0, 1'b0, '0, 2);
        total++; if (o_data !== '0) $display("FAIL abort_regs got=%h exp=0", o_data); else passed++;
    endtask

    initial begin
        for (int i = 0; i < MDEPTH; i++) m_mem[i] = 'x;
        test_reset();
        test_basic();
        test_arith();
        test_mem_wrap();
        test_zero_reg();
        test_overflow();
        test_mem_init();
        test_random();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
